alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one combinational 8-bit ALU among NUM_REQ requesters, such as the fetch/decode unit, the address generator and the debug port.
- Arbitrates round-robin and latches the winner's operation.
- Drives the ALU for exactly one cycle, registers the result and flags, then returns them with the requester ID over a valid/ready response channel.
- Sits between the core's requesters and the ALU instance; the ALU is external to this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept strobe to the granted requester.
- req_a  in  8*NUM_REQ  operand A; requester i uses slice [8i+7:8i].
- req_b  in  8*NUM_REQ  operand B, same slicing.
- req_imm  in  4*NUM_REQ  4-bit immediate per requester.
- req_use_imm  in  NUM_REQ  immediate-select per requester.
- req_op  in  4*NUM_REQ  4-bit ALU opcode per requester.
- alu_a, alu_b  out  8  operands driven to the ALU.
- alu_imm  out  4  immediate driven to the ALU.
- alu_use_imm  out  1  immediate-select driven to the ALU.
- alu_op  out  4  opcode driven to the ALU.
- alu_result  in  8  ALU result.
- alu_carry, alu_zero, alu_ovf, alu_unf  in  1 each  ALU flags.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  index of the requester being answered.
- resp_result  out  8  registered ALU result.
- resp_flags  out  4  registered flags as {unf, ovf, zero, carry}.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, rr_ptr=0, all latched operand registers 0.
  - resp_valid=0, resp_id=0, resp_result=0, resp_flags=0.
  - req_ready=0, busy=0; alu_* outputs are 0.
  - A transaction in flight is dropped silently.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req_valid bit is set, pick the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[g] is high combinationally in that same cycle; all other req_ready bits stay 0.
  - On the clock edge, latch the winner's a, b, imm, use_imm and op plus g, then go to EXEC.
  - If no request is pending, stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_* outputs are driven from the latched registers. They are 0 in every other state, so the ALU does not toggle.
  - On the clock edge, capture alu_result and the flags into resp_result/resp_flags, set resp_id=g and resp_valid=1, then go to RESP.
- RESP:
  - resp_valid and the resp_* fields are held stable until resp_ready is high.
  - On a cycle with resp_valid && resp_ready: clear resp_valid, set rr_ptr=(g+1) mod NUM_REQ, go to IDLE.
  - resp_result/resp_flags/resp_id keep their last values after the handshake.
- Latency and throughput:
  - Accept cycle t, EXEC at t+1, resp_valid at t+2.
  - Minimum 3 cycles per operation.
- Requester rules:
  - A requester holds req_valid and its operands stable until it sees req_ready.
  - Operand changes after acceptance have no effect.
- Simultaneous events:
  - A response handshake and new req_valid in the same cycle: the new request is arbitrated in the following IDLE cycle, never in RESP.
- Fairness: a requester that is continuously valid is granted within NUM_REQ grants.
- Opcode handling: opcodes are passed through unmodified. Width and semantics come from the ALU; this block never modifies results.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- When defined:
  - A latched opcode >= 4'b1000 takes the path IDLE -> RESP directly and skips EXEC; the ALU is not driven.
  - The response carries resp_result=8'h00 and resp_flags=4'b0000.
  - An extra output resp_err (1 bit) is 1 for that response and 0 otherwise; it resets to 0.
  - Latency for an illegal opcode is 1 cycle to resp_valid.
- When undefined:
  - There is no resp_err port.
  - All opcodes go through EXEC, and the ALU's default result (0, zero flag set) is returned.

Decomposition:
- Shared include/package alu_defs:
  - ALU opcode localparams: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_NOT=5, OP_SHL=6, OP_SHR=7, OP_LAST_LEGAL=7.
  - Flag bit indices: FLG_C=0, FLG_Z=1, FLG_O=2, FLG_U=3.
  - FSM state encodings.
- One sub-module: rr_arbiter.
  - Parameterized by N.
  - Inputs: request vector, pointer. Output: one-hot grant plus encoded index.
  - Purely combinational; the pointer is owned by the parent.

Test Plan:
- Single op: requester 1 sends A=8'hF0, B=8'h20, op=ADD. Expect req_ready[1] in cycle t, resp_valid at t+2, resp_id=1, resp_result=8'h10, resp_flags=4'b0101 (ovf=1, carry=1).
- Immediate SUB: requester 0 sends A=8'h03, imm=4'h5, use_imm=1, op=SUB. Expect resp_result=8'hFE, resp_flags=4'b1000.
- Round-robin: all 4 requesters continuously valid, resp_ready=1. Grant order 0,1,2,3,0; each response arrives 3 cycles apart with matching resp_id.
- Backpressure: resp_ready=0 for 5 cycles during RESP. resp_* stay stable, busy=1, req_ready stays 0; release gives exactly one response.
- Reset mid-EXEC: drop rst_n during EXEC. All outputs are 0 immediately (asynchronously); after release, a request from requester 2 is granted first from rr_ptr=0.
- OPCHECK (macro defined): op=4'b1010. Expect resp_valid 1 cycle after accept, resp_err=1, resp_result=0, and alu_op stays 0 throughout.

Source files
------------

// File: rtl/alu_defs.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU request arbiter.
// Consumers import alu_defs::*.
package alu_defs;

  localparam logic [3:0] OP_ADD        = 4'd0;
  localparam logic [3:0] OP_SUB        = 4'd1;
  localparam logic [3:0] OP_AND        = 4'd2;
  localparam logic [3:0] OP_OR         = 4'd3;
  localparam logic [3:0] OP_XOR        = 4'd4;
  localparam logic [3:0] OP_NOT        = 4'd5;
  localparam logic [3:0] OP_SHL        = 4'd6;
  localparam logic [3:0] OP_SHR        = 4'd7;
  localparam logic [3:0] OP_LAST_LEGAL = 4'd7;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_O = 2;
  localparam int FLG_U = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_valid
);

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      int idx;
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = W'(idx);
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin sharing of one external 8-bit ALU among NUM_REQ requesters.
// Optional macro ALU_ARB_OPCHECK_EN: illegal opcodes bypass the ALU and raise resp_err.
module alu_req_arbiter
  import alu_defs::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [4*NUM_REQ-1:0] req_imm,
  input  logic [NUM_REQ-1:0]   req_use_imm,
  input  logic [4*NUM_REQ-1:0] req_op,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [3:0]           alu_imm,
  output logic                 alu_use_imm,
  output logic [3:0]           alu_op,
  input  logic [7:0]           alu_result,
  input  logic                 alu_carry,
  input  logic                 alu_zero,
  input  logic                 alu_ovf,
  input  logic                 alu_unf,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [7:0]           resp_result,
  output logic [3:0]           resp_flags,
`ifdef ALU_ARB_OPCHECK_EN
  output logic                 resp_err,
`endif
  output logic                 busy
);

  arb_state_t state_reg, state_next;

  logic [ID_W-1:0] rr_ptr_reg;
  logic [ID_W-1:0] lat_id_reg;
  logic [7:0]      lat_a_reg, lat_b_reg;
  logic [3:0]      lat_imm_reg, lat_op_reg;
  logic            lat_use_imm_reg;
  logic            resp_valid_reg;
  logic [ID_W-1:0] resp_id_reg;
  logic [7:0]      resp_result_reg;
  logic [3:0]      resp_flags_reg;

  logic [7:0] a_arr   [NUM_REQ];
  logic [7:0] b_arr   [NUM_REQ];
  logic [3:0] imm_arr [NUM_REQ];
  logic [3:0] op_arr  [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign a_arr[gi]   = req_a[8*gi +: 8];
      assign b_arr[gi]   = req_b[8*gi +: 8];
      assign imm_arr[gi] = req_imm[4*gi +: 4];
      assign op_arr[gi]  = req_op[4*gi +: 4];
    end
  endgenerate

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_valid;

  rr_arbiter #(.N(NUM_REQ), .W(ID_W)) u_rr (
    .req         (req_valid),
    .ptr         (rr_ptr_reg),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

`ifdef ALU_ARB_OPCHECK_EN
  logic resp_err_reg;
  logic illegal_win;
  assign illegal_win = ~op_is_legal(op_arr[grant_idx]);
`endif

  logic [ID_W-1:0] ptr_after;
  assign ptr_after = (lat_id_reg == ID_W'(NUM_REQ - 1)) ? '0 : lat_id_reg + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          state_next = ST_EXEC;
`ifdef ALU_ARB_OPCHECK_EN
          if (illegal_win) state_next = ST_RESP;
`endif
        end
      end
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg      <= '0;
      lat_id_reg      <= '0;
      lat_a_reg       <= '0;
      lat_b_reg       <= '0;
      lat_imm_reg     <= '0;
      lat_op_reg      <= '0;
      lat_use_imm_reg <= 1'b0;
      resp_valid_reg  <= 1'b0;
      resp_id_reg     <= '0;
      resp_result_reg <= '0;
      resp_flags_reg  <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      resp_err_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            lat_id_reg      <= grant_idx;
            lat_a_reg       <= a_arr[grant_idx];
            lat_b_reg       <= b_arr[grant_idx];
            lat_imm_reg     <= imm_arr[grant_idx];
            lat_op_reg      <= op_arr[grant_idx];
            lat_use_imm_reg <= req_use_imm[grant_idx];
`ifdef ALU_ARB_OPCHECK_EN
            // Illegal opcode: answer immediately with a zeroed error response.
            if (illegal_win) begin
              resp_valid_reg  <= 1'b1;
              resp_id_reg     <= grant_idx;
              resp_result_reg <= '0;
              resp_flags_reg  <= '0;
              resp_err_reg    <= 1'b1;
            end
`endif
          end
        end
        ST_EXEC: begin
          resp_valid_reg        <= 1'b1;
          resp_id_reg           <= lat_id_reg;
          resp_result_reg       <= alu_result;
          resp_flags_reg[FLG_C] <= alu_carry;
          resp_flags_reg[FLG_Z] <= alu_zero;
          resp_flags_reg[FLG_O] <= alu_ovf;
          resp_flags_reg[FLG_U] <= alu_unf;
`ifdef ALU_ARB_OPCHECK_EN
          resp_err_reg          <= 1'b0;
`endif
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            rr_ptr_reg     <= ptr_after;
          end
        end
        default: ;
      endcase
    end
  end

  logic in_exec;
  assign in_exec = (state_reg == ST_EXEC);

  // ALU inputs are gated to zero outside EXEC so the ALU stays quiet.
  assign alu_a       = in_exec ? lat_a_reg       : '0;
  assign alu_b       = in_exec ? lat_b_reg       : '0;
  assign alu_imm     = in_exec ? lat_imm_reg     : '0;
  assign alu_use_imm = in_exec ? lat_use_imm_reg : 1'b0;
  assign alu_op      = in_exec ? lat_op_reg      : '0;

  assign req_ready   = (state_reg == ST_IDLE) ? grant : '0;
  assign busy        = (state_reg != ST_IDLE);
  assign resp_valid  = resp_valid_reg;
  assign resp_id     = resp_id_reg;
  assign resp_result = resp_result_reg;
  assign resp_flags  = resp_flags_reg;
`ifdef ALU_ARB_OPCHECK_EN
  assign resp_err    = resp_err_reg & resp_valid_reg;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed self-checking bench for alu_req_arbiter with a small behavioural ALU.
// Define ALU_ARB_OPCHECK_EN to exercise the illegal-opcode bypass.
module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready, req_use_imm;
  logic [31:0] req_a, req_b;
  logic [15:0] req_imm, req_op;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [3:0]  alu_imm, alu_op;
  logic        alu_use_imm, alu_carry, alu_zero, alu_ovf, alu_unf;
  logic        resp_valid, resp_ready, busy;
  logic [1:0]  resp_id;
  logic [7:0]  resp_result;
  logic [3:0]  resp_flags;
`ifdef ALU_ARB_OPCHECK_EN
  logic        resp_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_imm(req_imm),
    .req_use_imm(req_use_imm), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm),
    .alu_use_imm(alu_use_imm), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_ovf(alu_ovf), .alu_unf(alu_unf),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_flags(resp_flags),
`ifdef ALU_ARB_OPCHECK_EN
    .resp_err(resp_err),
`endif
    .busy(busy)
  );

  // Behavioural ALU: ovf = unsigned carry-out on ADD, unf = borrow on SUB.
  always_comb begin
    logic [8:0] sum;
    logic [7:0] bop;
    bop        = alu_use_imm ? {4'h0, alu_imm} : alu_b;
    sum        = 9'd0;
    alu_result = 8'h00;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    alu_unf    = 1'b0;
    case (alu_op)
      4'd0: begin sum = {1'b0, alu_a} + {1'b0, bop}; alu_result = sum[7:0];
                  alu_carry = sum[8]; alu_ovf = sum[8]; end
      4'd1: begin alu_result = alu_a - bop; alu_unf = (alu_a < bop); end
      4'd2: alu_result = alu_a & bop;
      4'd3: alu_result = alu_a | bop;
      4'd4: alu_result = alu_a ^ bop;
      4'd5: alu_result = ~alu_a;
      4'd6: begin alu_result = alu_a << 1; alu_carry = alu_a[7]; end
      4'd7: begin alu_result = alu_a >> 1; alu_carry = alu_a[0]; end
      default: alu_result = 8'h00;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] imm, input logic use_imm, input logic [3:0] op);
    req_valid[i]     = 1'b1;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    req_imm[4*i +: 4] = imm;
    req_use_imm[i]   = use_imm;
    req_op[4*i +: 4] = op;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_imm = '0;
    req_use_imm = '0; req_op = '0; resp_ready = 1'b1;
    tick; tick;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset.busy got=%b exp=0", busy); end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset.resp_valid got=%b exp=0", resp_valid); end
    n_vec++; if ({resp_id, resp_result, resp_flags} !== 14'h0) begin n_err++;
      $display("FAIL reset.resp_fields got=%h/%h/%h exp=0", resp_id, resp_result, resp_flags); end
    rst_n = 1'b1;
    tick;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset.req_ready got=%b exp=0000", req_ready); end
    n_vec++; if (alu_op !== 4'h0 || alu_a !== 8'h00) begin n_err++;
      $display("FAIL reset.alu got op=%h a=%h exp=0", alu_op, alu_a); end
  endtask

  task automatic test_single_op;
    set_req(1, 8'hF0, 8'h20, 4'h0, 1'b0, 4'd0);
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL single.req_ready got=%b exp=0010", req_ready); end
    tick; req_valid = '0;
    n_vec++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin n_err++;
      $display("FAIL single.exec got busy=%b valid=%b exp busy=1 valid=0", busy, resp_valid); end
    n_vec++; if (alu_a !== 8'hF0 || alu_b !== 8'h20 || alu_op !== 4'd0) begin n_err++;
      $display("FAIL single.alu_drive got a=%h b=%h op=%h exp F0/20/0", alu_a, alu_b, alu_op); end
    tick;
    n_vec++; if (resp_valid !== 1'b1 || resp_id !== 2'd1) begin n_err++;
      $display("FAIL single.resp got valid=%b id=%0d exp valid=1 id=1", resp_valid, resp_id); end
    n_vec++; if (resp_result !== 8'h10 || resp_flags !== 4'b0101) begin n_err++;
      $display("FAIL single.result got %h/%b exp 10/0101", resp_result, resp_flags); end
    n_vec++; if (alu_a !== 8'h00) begin n_err++; $display("FAIL single.alu_idle got a=%h exp 00", alu_a); end
`ifdef ALU_ARB_OPCHECK_EN
    n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL single.resp_err got=%b exp=0", resp_err); end
`endif
    tick;
    n_vec++; if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_result !== 8'h10) begin n_err++;
      $display("FAIL single.after got valid=%b busy=%b res=%h exp 0/0/10", resp_valid, busy, resp_result); end
  endtask

  task automatic test_imm_sub;
    set_req(0, 8'h03, 8'hAA, 4'h5, 1'b1, 4'd1);
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL imm.req_ready got=%b exp=0001", req_ready); end
    tick; req_valid = '0;
    n_vec++; if (alu_use_imm !== 1'b1 || alu_imm !== 4'h5 || alu_op !== 4'd1) begin n_err++;
      $display("FAIL imm.alu_drive got use=%b imm=%h op=%h exp 1/5/1", alu_use_imm, alu_imm, alu_op); end
    tick;
    n_vec++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_result !== 8'hFE || resp_flags !== 4'b1000) begin
      n_err++; $display("FAIL imm.resp got v=%b id=%0d res=%h fl=%b exp 1/0/FE/1000",
                        resp_valid, resp_id, resp_result, resp_flags); end
    tick;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy;
    rst_n = 1'b0; tick; rst_n = 1'b1; tick;
    for (int i = 0; i < 4; i++) set_req(i, 8'(16*i + 1), 8'h01, 4'h0, 1'b0, 4'd0);
    for (int k = 0; k < 5; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      #1;
      n_vec++; if (req_ready !== exp_rdy) begin n_err++;
        $display("FAIL rr.grant%0d got=%b exp=%b", k, req_ready, exp_rdy); end
      tick; tick;
      n_vec++; if (resp_valid !== 1'b1 || resp_id !== 2'(k % 4) || resp_result !== 8'(16*(k % 4) + 2)) begin
        n_err++; $display("FAIL rr.resp%0d got v=%b id=%0d res=%h exp 1/%0d/%h",
                          k, resp_valid, resp_id, resp_result, k % 4, 8'(16*(k % 4) + 2)); end
      tick;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    set_req(0, 8'h01, 8'h02, 4'h0, 1'b0, 4'd0);
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp.req_ready got=%b exp=0001", req_ready); end
    tick; req_valid = '0;
    set_req(3, 8'h40, 8'h04, 4'h0, 1'b0, 4'd0);
    resp_ready = 1'b0;
    tick;
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (resp_valid !== 1'b1 || resp_result !== 8'h03 || resp_id !== 2'd0 || busy !== 1'b1 ||
                   req_ready !== 4'b0000) begin n_err++;
        $display("FAIL bp.hold%0d got v=%b res=%h id=%0d busy=%b rdy=%b exp 1/03/0/1/0000",
                 c, resp_valid, resp_result, resp_id, busy, req_ready); end
      tick;
    end
    resp_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp.handshake_rdy got=%b exp=0000", req_ready); end
    tick;
    n_vec++; if (resp_valid !== 1'b0 || req_ready !== 4'b1000) begin n_err++;
      $display("FAIL bp.release got v=%b rdy=%b exp 0/1000", resp_valid, req_ready); end
    tick; req_valid = '0;
    tick;
    n_vec++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_result !== 8'h44) begin n_err++;
      $display("FAIL bp.next got v=%b id=%0d res=%h exp 1/3/44", resp_valid, resp_id, resp_result); end
    tick;
  endtask

  task automatic test_reset_mid_exec;
    set_req(2, 8'h10, 8'h20, 4'h0, 1'b0, 4'd0);
    tick; req_valid = '0;
    tick;
    n_vec++; if (resp_id !== 2'd2 || resp_result !== 8'h30) begin n_err++;
      $display("FAIL rst.pre got id=%0d res=%h exp 2/30", resp_id, resp_result); end
    tick;
    set_req(3, 8'h01, 8'h01, 4'h0, 1'b0, 4'd0);
    #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rst.grant3 got=%b exp=1000", req_ready); end
    tick; req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_result !== 8'h00 ||
                 resp_flags !== 4'h0) begin n_err++;
      $display("FAIL rst.async got busy=%b v=%b id=%0d res=%h fl=%b exp all 0",
               busy, resp_valid, resp_id, resp_result, resp_flags); end
    n_vec++; if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 4'h0) begin n_err++;
      $display("FAIL rst.alu got a=%h b=%h op=%h exp 0", alu_a, alu_b, alu_op); end
    tick; rst_n = 1'b1;
    set_req(2, 8'h05, 8'h05, 4'h0, 1'b0, 4'd0);
    set_req(3, 8'h07, 8'h07, 4'h0, 1'b0, 4'd0);
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rst.ptr0 got=%b exp=0100", req_ready); end
    tick; req_valid = '0;
    tick;
    n_vec++; if (resp_id !== 2'd2 || resp_result !== 8'h0A) begin n_err++;
      $display("FAIL rst.post got id=%0d res=%h exp 2/0A", resp_id, resp_result); end
    tick;
  endtask

  task automatic test_illegal_op;
    set_req(1, 8'h55, 8'h66, 4'h0, 1'b0, 4'b1010);
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL ill.req_ready got=%b exp=0010", req_ready); end
    tick; req_valid = '0;
`ifdef ALU_ARB_OPCHECK_EN
    n_vec++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_result !== 8'h00 || resp_flags !== 4'h0 ||
                 resp_id !== 2'd1) begin n_err++;
      $display("FAIL ill.resp got v=%b err=%b res=%h fl=%b id=%0d exp 1/1/00/0000/1",
               resp_valid, resp_err, resp_result, resp_flags, resp_id); end
    n_vec++; if (alu_op !== 4'h0) begin n_err++; $display("FAIL ill.alu_op got=%h exp=0", alu_op); end
    tick;
    n_vec++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || alu_op !== 4'h0) begin n_err++;
      $display("FAIL ill.after got v=%b err=%b op=%h exp 0/0/0", resp_valid, resp_err, alu_op); end
`else
    n_vec++; if (alu_op !== 4'b1010 || resp_valid !== 1'b0) begin n_err++;
      $display("FAIL ill.exec got op=%h v=%b exp A/0", alu_op, resp_valid); end
    tick;
    n_vec++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_result !== 8'h00 || resp_flags !== 4'b0010) begin
      n_err++; $display("FAIL ill.resp got v=%b id=%0d res=%h fl=%b exp 1/1/00/0010",
                        resp_valid, resp_id, resp_result, resp_flags); end
    tick;
`endif
  endtask

  initial begin
    test_reset;
    test_single_op;
    test_imm_sub;
    test_round_robin;
    test_backpressure;
    test_reset_mid_exec;
    test_illegal_op;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
